// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver (start, 8 data bits LSB first, stop)
// with a 2-FF input synchronizer and a valid/ready output register.
//
// Parameters:
//   CLOCK_FREQUENCY  clk frequency in Hz
//   BAUD_RATE        line rate in bit/s (CLOCK_FREQUENCY/BAUD_RATE >= 4)
// Ports:
//   clk          single rising-edge clock
//   reset        synchronous active-high reset
//   in           asynchronous serial line, idles high
//   data_out     received byte, stable while valid is high
//   valid        byte available
//   ready        consumer accepts the byte
//   busy         receiver FSM is not idle
//   frame_error  one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: completed byte dropped (output full)
// Build option:
//   UART_RECEIVER_MAJORITY_EN  each bit decision is the 2-of-3 majority
//                              of the three cycles ending at the sample
//                              point; otherwise a single sample is used.
module uart_receiver #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int BIT_TICKS  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CW         = $clog2(BIT_TICKS);

    localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t state;
    state_t state_n;

    logic          sync1;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic [7:0]    data_n;
    logic          valid_n;
    logic          fe_n;
    logic          ov_n;
    logic          tick;
    logic          bit_val;

    // ------------------------------------------------------------
    // Input synchronizer; primed high so reset never looks like a
    // start edge.
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= in;
            rxs   <= sync1;
        end
    end

    assign tick = (cnt == '0);

`ifdef UART_RECEIVER_MAJORITY_EN
    // hist[1] holds rxs from two cycles ago (cnt == 2 at the sample
    // point), hist[0] from the previous cycle (cnt == 1).
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxs};
        end
    end

    assign bit_val = (hist[1] & hist[0])
                   | (hist[1] & rxs)
                   | (hist[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    // ------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shift       <= shift_n;
            data_out    <= data_n;
            valid       <= valid_n;
            frame_error <= fe_n;
            overrun     <= ov_n;
        end
    end

    // ------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------
    always_comb begin
        state_n = state;
        cnt_n   = tick ? cnt : cnt - CW'(1);
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_out;
        valid_n = valid & ~ready;
        fe_n    = 1'b0;
        ov_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_n   = CNT_HALF;
                    state_n = START;
                end
            end

            START: begin
                if (tick) begin
                    if (bit_val) begin
                        // Line went back high: a glitch, not a frame.
                        state_n = IDLE;
                    end else begin
                        cnt_n   = CNT_BIT;
                        idx_n   = '0;
                        state_n = DATA;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    // LSB arrives first, so shift in from the top.
                    shift_n = {bit_val, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    cnt_n   = CNT_BIT;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (bit_val) begin
                        // The output register is free if it is empty
                        // or being drained in this very cycle.
                        if (!valid || ready) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end else begin
                            ov_n = 1'b1;
                        end
                        state_n = IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = BRK;
                    end
                end
            end

            BRK: begin
                // Hold off until the line releases so a stuck-low
                // line is not decoded as a stream of zero frames.
                if (rxs) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver at 16 clocks
// per bit; frames are built from plain bit arithmetic in the bench.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int BT = 16;
    localparam int FRAME = 10 * BT;
    localparam int LAT = 3 + BT / 2 + 9 * BT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = 0;

    logic [7:0] acc_q[$];
    int         rise_q[$];
    int         fe_cnt = 0;
    int         fe_cyc = 0;
    int         ov_cnt = 0;
    int         ov_cyc = 0;
    int         v_hi = 0;
    bit         busy_seen = 0;
    bit         vprev = 0;

    uart_receiver #(
        .CLOCK_FREQUENCY(1_600_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in(rx),
        .data_out(data_out),
        .valid(valid),
        .ready(ready),
        .busy(busy),
        .frame_error(frame_error),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: logs handshake beats and status pulses mid-cycle.
    always @(negedge clk) begin
        if (valid === 1'b1 && !vprev) rise_q.push_back(cyc);
        if (valid === 1'b1 && ready === 1'b1) acc_q.push_back(data_out);
        if (frame_error === 1'b1) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (overrun === 1'b1) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen = 1;
        if (valid === 1'b1) v_hi++;
        vprev = (valid === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        acc_q.delete();
        rise_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        v_hi = 0;
        busy_seen = 0;
    endtask

    // Drives len cycles of a frame; spike_at inverts one cycle,
    // rdy_at raises ready for exactly one cycle.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int rdy_at, input int len,
                              input int spike_at);
        last_start = cyc;
        for (int k = 0; k < len; k++) begin
            int   slot;
            logic lv;
            slot = k / BT;
            if (slot == 0) lv = 1'b0;
            else if (slot <= 8) lv = b[slot-1];
            else lv = stop_ok;
            if (k == spike_at) lv = ~lv;
            rx = lv;
            if (k == rdy_at) ready = 1'b1;
            else if (rdy_at >= 0 && k == rdy_at + 1) ready = 1'b0;
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        ready = 1'b0;
        tick(3);
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL rst_data: got %h want 00", data_out);
        end
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid: got %b want 0", valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        total++;
        if ({frame_error, overrun} !== 2'b00) begin
            bad++;
            $display("FAIL rst_flags: got %b want 00",
                     {frame_error, overrun});
        end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_single();
        int c0;
        clear_log();
        ready = 1'b1;
        c0 = cyc;
        send_frame(8'hA5, 1, -1, FRAME, -1);
        tick(20);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== 8'hA5) begin
            bad++;
            $display("FAIL single_data: got n=%0d d=%h want n=1 d=a5",
                     acc_q.size(), data_out);
        end
        total++;
        if (rise_q.size() != 1 || rise_q[0] - c0 != LAT) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d",
                     rise_q.size() ? rise_q[0] - c0 : -1, LAT);
        end
        total++;
        if (v_hi != 1) begin
            bad++;
            $display("FAIL single_valid_len: got %0d want 1", v_hi);
        end
        total++;
        if (busy !== 1'b0 || fe_cnt != 0 || ov_cnt != 0) begin
            bad++;
            $display("FAIL single_idle: got busy=%b fe=%0d ov=%0d want 0",
                     busy, fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        exp_q = '{8'h00, 8'hFF, 8'h55};
        clear_log();
        ready = 1'b1;
        foreach (exp_q[i]) send_frame(exp_q[i], 1, -1, FRAME, -1);
        tick(20);
        total++;
        if (acc_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count: got %0d want %0d",
                     acc_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (acc_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL b2b_data%0d: got %h want %h",
                             i, acc_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (rise_q.size() != 3 || rise_q[2] - rise_q[1] != FRAME) begin
            bad++;
            $display("FAIL b2b_spacing: got n=%0d want n=3 gap=%0d",
                     rise_q.size(), FRAME);
        end
        total++;
        if (fe_cnt != 0 || ov_cnt != 0) begin
            bad++;
            $display("FAIL b2b_errors: got fe=%0d ov=%0d want 0",
                     fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_frame_error();
        int c0;
        clear_log();
        ready = 1'b1;
        c0 = cyc;
        send_frame(8'h96, 0, -1, FRAME, -1);
        rx = 1'b0;
        tick(40 * BT);
        total++;
        if (fe_cnt != 1 || fe_cyc - c0 != LAT) begin
            bad++;
            $display("FAIL fe_pulse: got n=%0d at %0d want n=1 at %0d",
                     fe_cnt, fe_cyc - c0, LAT);
        end
        total++;
        if (busy !== 1'b1 || rise_q.size() != 0) begin
            bad++;
            $display("FAIL fe_break: got busy=%b beats=%0d want 1 0",
                     busy, rise_q.size());
        end
        rx = 1'b1;
        tick(4);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL fe_release: got busy=%b want 0", busy);
        end
        tick(10);
        send_frame(8'h3C, 1, -1, FRAME, -1);
        tick(20);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== 8'h3C || fe_cnt != 1) begin
            bad++;
            $display("FAIL fe_next: got n=%0d d=%h fe=%0d want 1 3c 1",
                     acc_q.size(), data_out, fe_cnt);
        end
    endtask

    task automatic test_handshake();
        int c2;
        clear_log();
        ready = 1'b0;
        send_frame(8'h11, 1, -1, FRAME, -1);
        c2 = cyc;
        send_frame(8'h22, 1, -1, FRAME, -1);
        tick(10);
        total++;
        if (valid !== 1'b1 || data_out !== 8'h11) begin
            bad++;
            $display("FAIL hs_hold: got v=%b d=%h want 1 11",
                     valid, data_out);
        end
        total++;
        if (ov_cnt != 1 || ov_cyc - c2 != LAT) begin
            bad++;
            $display("FAIL hs_overrun: got n=%0d at %0d want 1 at %0d",
                     ov_cnt, ov_cyc - c2, LAT);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        total++;
        if (valid !== 1'b0 || acc_q.size() != 1 || acc_q[0] !== 8'h11) begin
            bad++;
            $display("FAIL hs_drain: got v=%b n=%0d want 0 1",
                     valid, acc_q.size());
        end
        send_frame(8'h33, 1, -1, FRAME, -1);
        send_frame(8'h44, 1, LAT - 1, FRAME, -1);
        tick(5);
        total++;
        if (valid !== 1'b1 || data_out !== 8'h44 || ov_cnt != 1) begin
            bad++;
            $display("FAIL hs_same_cycle: got v=%b d=%h ov=%0d want 1 44 1",
                     valid, data_out, ov_cnt);
        end
        ready = 1'b1;
        tick(2);
        total++;
        if (acc_q.size() != 3 || acc_q[1] !== 8'h33 || acc_q[2] !== 8'h44) begin
            bad++;
            $display("FAIL hs_order: got n=%0d want 3 (11 33 44)",
                     acc_q.size());
        end
    endtask

    task automatic test_glitch();
        clear_log();
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        total++;
        if (!busy_seen || busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_busy: got seen=%0d now=%b want 1 0",
                     busy_seen, busy);
        end
        total++;
        if (rise_q.size() != 0 || fe_cnt != 0 || ov_cnt != 0) begin
            bad++;
            $display("FAIL glitch_out: got beats=%0d fe=%0d ov=%0d want 0",
                     rise_q.size(), fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        ready = 1'b1;
        send_frame(8'h5A, 1, -1, 4 * BT, -1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rmid_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        tick(1);
        total++;
        if ({data_out, valid, busy, frame_error, overrun} !== 12'h000) begin
            bad++;
            $display("FAIL rmid_outputs: got d=%h v=%b b=%b fe=%b ov=%b want 0",
                     data_out, valid, busy, frame_error, overrun);
        end
        reset = 1'b0;
        rx = 1'b1;
        tick(40);
        send_frame(8'hC3, 1, -1, FRAME, -1);
        tick(20);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== 8'hC3) begin
            bad++;
            $display("FAIL rmid_next: got n=%0d d=%h want 1 c3",
                     acc_q.size(), data_out);
        end
    endtask

    // One-cycle inversion timed to reach rxs exactly at the bit-3
    // sample point: majority voting rejects it, a single sample does not.
    task automatic test_spike();
        logic [7:0] want;
`ifdef UART_RECEIVER_MAJORITY_EN
        want = 8'h0F;
`else
        want = 8'h07;
`endif
        clear_log();
        ready = 1'b1;
        send_frame(8'h0F, 1, -1, FRAME, 4 * BT + BT / 2);
        tick(20);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== want) begin
            bad++;
            $display("FAIL spike_data: got n=%0d d=%h want 1 %h",
                     acc_q.size(), data_out, want);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         fe_exp;
        fe_exp = 0;
        clear_log();
        ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            bit         ok;
            b = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, -1, FRAME, -1);
            rx = 1'b1;
            if (ok) begin
                exp_q.push_back(b);
                tick($urandom_range(0, 10));
            end else begin
                fe_exp++;
                tick($urandom_range(20, 40));
            end
        end
        tick(20);
        total++;
        if (acc_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d want %0d",
                     acc_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (acc_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand_data%0d: got %h want %h",
                             i, acc_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (fe_cnt != fe_exp || ov_cnt != 0) begin
            bad++;
            $display("FAIL rand_flags: got fe=%0d ov=%0d want %0d 0",
                     fe_cnt, ov_cnt, fe_exp);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_error();
        test_handshake();
        test_glitch();
        test_reset_mid();
        test_spike();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the downstream counterpart of the transmitter, consuming its `out` line. It converts the 8N1 frame (start bit, 8 data bits LSB first, one stop bit) back to a byte. The byte is presented on a valid/ready handshake with framing and overrun status. It sits between the pin and the consuming logic, in the same clock domain as the transmitter.

## Interface
- `CLOCK_FREQUENCY`, default 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- Derived localparams, integer division:
  - `BIT_TICKS = CLOCK_FREQUENCY / BAUD_RATE`; must be ≥ 4.
  - `HALF_TICKS = BIT_TICKS / 2`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  1  asynchronous serial line; idles high.
- `data_out`  out  8  received byte; stable while `valid` is high.
- `valid`  out  1  byte available.
- `ready`  in  1  consumer accepts the byte.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer.** `in` passes through a 2-FF synchronizer (both FFs reset to 1). All decisions use the synchronized signal `rxs`.
- **Counter.** Countdown counter `cnt`, width `$clog2(BIT_TICKS)`. The sample point is the cycle `cnt == 0`.
- **IDLE:**
  - Wait for `rxs == 0`.
  - Then load `cnt = HALF_TICKS-1` and go to START.
- **START:** at the sample point:
  - If the sampled bit is 1 (glitch), go to IDLE with no output.
  - Otherwise load `cnt = BIT_TICKS-1`, clear the bit index, and go to DATA.
- **DATA:**
  - At each sample point, shift the sampled bit into a shift register from the MSB side, so the byte is assembled LSB first.
  - Increment the 3-bit index and reload `cnt = BIT_TICKS-1`.
  - After the 8th bit, go to STOP.
- **STOP:** at the sample point:
  - **Sampled 1:**
    - If the output register is free (`!valid`, or `valid && ready` this cycle), load `data_out` and set `valid`.
    - Otherwise pulse `overrun`, drop the new byte, and keep the old `data_out` and `valid`.
    - Go to IDLE.
  - **Sampled 0:**
    - Pulse `frame_error`; do not assert `valid`.
    - Go to BREAK.
- **BREAK:** wait for `rxs == 1`, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- **Handshake:**
  - `valid` stays high until a cycle with `ready` high, and clears on the next edge.
  - `ready` while `!valid` has no effect.
  - When a byte completes in the same cycle as `valid && ready`, the new byte loads and `valid` stays high; no overrun is flagged.
- **Reset:**
  - Any cycle with `reset` high forces IDLE, including mid-frame.
  - Outputs reset to: `data_out = 8'h00`, `valid = 0`, `busy = 0`, `frame_error = 0`, `overrun = 0`.
  - The counter, index and shift register are cleared.
  - After reset the synchronizer is primed high, so a partial frame still in progress on the line is resynchronized only on the next falling edge seen from IDLE.
- The FSM returns to IDLE at the middle of the stop bit, so back-to-back frames are received without loss.

## Timing
- Falling edge of `in` to first `rxs == 0`: 2 cycles.
- IDLE→START transition: 1 cycle after `rxs` goes low.
- Start sample: `HALF_TICKS` cycles after entering START.
- Each data bit and the stop bit: `BIT_TICKS` cycles apart.
- `valid`, `frame_error` and `overrun` are registered: they assert on the edge following the stop sample.
- Falling edge of `in` to `valid` high: 3 + `HALF_TICKS` + 9·`BIT_TICKS` cycles.
- `busy` rises 1 cycle after `rxs` goes low. It falls on the same edge `valid` rises, or on exit from BREAK.
- Tolerated baud mismatch: ±4 % between transmitter and receiver.

## Configuration
- Macro: `UART_RECEIVER_MAJORITY_EN`.
- **Defined:** every bit decision (start, data, stop) is the 2-of-3 majority of `rxs` sampled at `cnt` = 2, 1 and 0 of that bit period.
- **Undefined:** a single sample at `cnt == 0`.
- The sample point, all latencies and the interface are identical in both builds.

## Test plan
Bench parameters: `CLOCK_FREQUENCY = 1_600_000`, `BAUD_RATE = 100_000` (`BIT_TICKS = 16`).
- **Single byte:** frame 8'hA5 with `ready` tied high → `data_out = 8'hA5`, `valid` high for exactly 1 cycle, 3+8+144 = 155 cycles after the start edge.
- **Back-to-back:** frames 8'h00, 8'hFF, 8'h55 with no idle gap → three valid beats with the correct values; no errors.
- **Framing error and break:** stop bit driven low, then line held low for 40 bit times → one `frame_error` pulse, no `valid`, `busy` high until the line rises. A following 8'h3C frame is received correctly.
- **Handshake and overrun:**
  - `ready` low while two frames 8'h11 and 8'h22 arrive → `data_out` stays 8'h11, `overrun` pulses once at the second stop sample.
  - `ready` then pulsed → `valid` clears.
  - `ready` pulsed on the exact stop-sample cycle of a second byte → new byte loaded, no overrun.
- **Glitch and reset:**
  - 3-cycle low glitch on idle line → returns to IDLE, no output.
  - `reset` asserted mid-DATA → all outputs 0 next cycle; next full frame received correctly.
- **Majority build:** with `UART_RECEIVER_MAJORITY_EN` defined, a 1-cycle inverted spike at `cnt == 0` of bit 3 of frame 8'h0F → 8'h0F still received.
